vu_vmu_ctrl_ut_mc: RTL and testbench
====================================

VU_VMU_CTRL_UT_MC -- requirements
Module: vu_vmu_ctrl_ut_mc

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
- VLEN_SZ, 11, vector-length-minus-one field width.
- ADDR_SZ, 32, UT immediate/address width.
- CMD_SZ, 8, command-code field width.
- AMO_IMM, 0, 1 = AMO pops utmimmq and requires utmimmq_val.
- ERRCNT_SZ, 8, error counter width.
REQ-002 Ports SHALL be (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock.
- reset_n, in, 1, reset, synchronous, active-low.
- utmcmdq_bits, in, CMD_SZ+VLEN_SZ, {cmdcode, vlen_m1}.
- utmcmdq_val, in, 1, command valid.
- utmcmdq_rdy, out, 1, command pop.
- utmimmq_bits, in, ADDR_SZ, address.
- utmimmq_val, in, 1, immediate valid.
- utmimmq_rdy, out, 1, immediate pop.
- utmrespq_bits, out, 2, response code.
- utmrespq_val, out, 1, response valid.
- utmrespq_rdy, in, 1, response accept.
- iscmdq_enq_bits, out, ADDR_SZ+VLEN_SZ, {addr, vlen}.
- iscmdq_enq_val / iscmdq_enq_rdy, out / in, 1 each, issue command handshake.
- wbcmdq_enq_bits, out, 5+VLEN_SZ, {amo, cmd[3:0], vlen}.
- wbcmdq_enq_val / wbcmdq_enq_rdy, out / in, 1 each, writeback command handshake.
- stcmdq_enq_bits, out, 6+ADDR_SZ+VLEN_SZ, {amo, cmd[4:0], addr, vlen}.
- stcmdq_enq_val / stcmdq_enq_rdy, out / in, 1 each, store command handshake.
- issue_busy, in, 1, issue unit has work in flight.
- store_busy, in, 1, store unit has work in flight.
- err_cnt, out, ERRCNT_SZ, saturating count of invalid commands.

Function
REQ-003 Decode on cmd[7:4]:
- 0000 with cmd[3:2]=11: SYNC.
- 1100: LOAD.
- 1101: STORE.
- 1110 or 1111: AMO.
- anything else: INVALID.
REQ-004 LOAD SHALL fire in state IDLE when utmcmdq_val & utmimmq_val & iscmdq_enq_rdy & wbcmdq_enq_rdy & ~store_busy. On fire, in the same cycle: utmcmdq_rdy, utmimmq_rdy, iscmdq_enq_val and wbcmdq_enq_val SHALL all be 1; amo bit = 0.
REQ-005 STORE SHALL fire in IDLE when utmcmdq_val & utmimmq_val & stcmdq_enq_rdy & ~issue_busy. On fire: utmcmdq_rdy, utmimmq_rdy and stcmdq_enq_val SHALL be 1; amo bit = 0.
REQ-006 AMO SHALL fire in IDLE when utmcmdq_val & stcmdq_enq_rdy & wbcmdq_enq_rdy & ~issue_busy, additionally gated by utmimmq_val when AMO_IMM=1. On fire: utmcmdq_rdy, stcmdq_enq_val and wbcmdq_enq_val SHALL be 1; utmimmq_rdy = AMO_IMM; amo bit = 1.
REQ-007 LOAD, STORE and AMO SHALL have zero-cycle dispatch latency and sustain one command per cycle back-to-back.
REQ-008 No enq_val SHALL assert unless its command fires; enq_val SHALL never depend on its own queue's rdy outside the fire term.
REQ-009 FSM states SHALL be IDLE, SYNC, RESP.
REQ-010 IDLE with valid SYNC or INVALID SHALL go to SYNC or RESP respectively; neither pops in IDLE.
REQ-011 SYNC SHALL wait for ~store_busy & ~issue_busy. It then pops the command and drives utmrespq_val=1 with bits=2'd1: if utmrespq_rdy, go to IDLE; else go to RESP holding code 1.
REQ-012 An INVALID entry to RESP SHALL pop the command in its first RESP cycle, drive response code 2'd2, and increment err_cnt once, saturating at all-ones.
REQ-013 RESP SHALL hold utmrespq_val and the stored code stable until utmrespq_rdy, then return to IDLE; no dispatch SHALL occur in SYNC or RESP.
REQ-014 utmcmdq_rdy SHALL pulse exactly one cycle per command.

Reset
REQ-015 While reset_n=0 at a clk edge: state=IDLE, err_cnt=0, stored response code=0. All val/rdy outputs SHALL be 0 while state=IDLE with no fire.
REQ-016 Reset asserted during SYNC or RESP SHALL abandon the pending response without emitting it.

Structure
REQ-017 Package vu_vmu_ut_pkg SHALL hold command opcodes, response codes (NONE=0, SYNC=1, ERR=2), FSM state enum and field widths.
REQ-018 Decode SHALL be one combinational sub-module vu_vmu_ut_decode (cmd -> is_ld/is_st/is_amo/is_sync/is_inv).

Verification
REQ-019 Three LOADs vlen=7, addr 0x100/0x200/0x300, all rdy=1 -> three consecutive cycles of iscmdq bits {0x100,7} etc.; wbcmdq amo=0.
REQ-020 STORE with issue_busy=1 for 4 cycles -> no pop; fires on cycle 5, stcmdq amo=0.
REQ-021 AMO cmd 0xE0 with AMO_IMM=0 and utmimmq_val=0 -> fires; utmimmq_rdy=0; amo=1 on both queues.
REQ-022 SYNC 0x0C with store_busy=1 for 3 cycles, utmrespq_rdy low 2 cycles -> response code 1 held stable through both stall cycles, then return to IDLE.
REQ-023 300 invalid cmds 0x20 -> 300 code-2 responses; err_cnt saturates at 255.
REQ-024 reset_n low during RESP -> utmrespq_val=0 next cycle; err_cnt=0.

Source files
------------

// File: rtl/vu_vmu_ut_pkg.sv
// Shared opcodes, response codes, FSM state encoding and default field widths
// for the vector memory unit UT command controller.
package vu_vmu_ut_pkg;

    localparam int unsigned VlenSzDef   = 11;
    localparam int unsigned AddrSzDef   = 32;
    localparam int unsigned CmdSzDef    = 8;
    localparam int unsigned ErrCntSzDef = 8;

    // Low command bits forwarded to the writeback and store queues.
    localparam int unsigned WbCmdSz = 4;
    localparam int unsigned StCmdSz = 5;

    localparam logic [3:0] OpSync  = 4'b0000;
    localparam logic [3:0] OpLoad  = 4'b1100;
    localparam logic [3:0] OpStore = 4'b1101;
    localparam logic [2:0] OpAmo   = 3'b111;
    localparam logic [1:0] SyncSub = 2'b11;

    typedef enum logic [1:0] {
        RespNone = 2'd0,
        RespSync = 2'd1,
        RespErr  = 2'd2
    } resp_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSync = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/vu_vmu_ctrl_ut_mc_if.sv
// Command, immediate and response queues from the UT side plus the three
// dispatch queues toward issue, writeback and store.
interface vu_vmu_ctrl_ut_mc_if
    import vu_vmu_ut_pkg::*;
#(
    parameter int unsigned VLEN_SZ = VlenSzDef,
    parameter int unsigned ADDR_SZ = AddrSzDef,
    parameter int unsigned CMD_SZ  = CmdSzDef
);

    logic [CMD_SZ+VLEN_SZ-1:0]    utmcmdq_bits;
    logic                         utmcmdq_val;
    logic                         utmcmdq_rdy;

    logic [ADDR_SZ-1:0]           utmimmq_bits;
    logic                         utmimmq_val;
    logic                         utmimmq_rdy;

    logic [1:0]                   utmrespq_bits;
    logic                         utmrespq_val;
    logic                         utmrespq_rdy;

    logic [ADDR_SZ+VLEN_SZ-1:0]   iscmdq_enq_bits;
    logic                         iscmdq_enq_val;
    logic                         iscmdq_enq_rdy;

    logic [5+VLEN_SZ-1:0]         wbcmdq_enq_bits;
    logic                         wbcmdq_enq_val;
    logic                         wbcmdq_enq_rdy;

    logic [6+ADDR_SZ+VLEN_SZ-1:0] stcmdq_enq_bits;
    logic                         stcmdq_enq_val;
    logic                         stcmdq_enq_rdy;

    modport master (
        input  utmcmdq_bits,
        input  utmcmdq_val,
        output utmcmdq_rdy,
        input  utmimmq_bits,
        input  utmimmq_val,
        output utmimmq_rdy,
        output utmrespq_bits,
        output utmrespq_val,
        input  utmrespq_rdy,
        output iscmdq_enq_bits,
        output iscmdq_enq_val,
        input  iscmdq_enq_rdy,
        output wbcmdq_enq_bits,
        output wbcmdq_enq_val,
        input  wbcmdq_enq_rdy,
        output stcmdq_enq_bits,
        output stcmdq_enq_val,
        input  stcmdq_enq_rdy
    );

    modport slave (
        output utmcmdq_bits,
        output utmcmdq_val,
        input  utmcmdq_rdy,
        output utmimmq_bits,
        output utmimmq_val,
        input  utmimmq_rdy,
        input  utmrespq_bits,
        input  utmrespq_val,
        output utmrespq_rdy,
        input  iscmdq_enq_bits,
        input  iscmdq_enq_val,
        output iscmdq_enq_rdy,
        input  wbcmdq_enq_bits,
        input  wbcmdq_enq_val,
        output wbcmdq_enq_rdy,
        input  stcmdq_enq_bits,
        input  stcmdq_enq_val,
        output stcmdq_enq_rdy
    );

endinterface

// File: rtl/vu_vmu_ut_decode.sv
// Combinational classification of a UT memory command code into exactly one
// of load, store, AMO, sync or invalid.
module vu_vmu_ut_decode
    import vu_vmu_ut_pkg::*;
(
    input  logic [7:2] cmd_i,
    output logic       is_ld_o,
    output logic       is_st_o,
    output logic       is_amo_o,
    output logic       is_sync_o,
    output logic       is_inv_o
);

    always_comb begin
        is_ld_o   = (cmd_i[7:4] == OpLoad);
        is_st_o   = (cmd_i[7:4] == OpStore);
        is_amo_o  = (cmd_i[7:5] == OpAmo);
        is_sync_o = (cmd_i[7:4] == OpSync) && (cmd_i[3:2] == SyncSub);
        is_inv_o  = ~(is_ld_o | is_st_o | is_amo_o | is_sync_o);
    end

endmodule

// File: rtl/vu_vmu_ctrl_ut_mc.sv
// UT memory command controller: dispatches loads, stores and AMOs with zero
// latency and serialises sync/invalid commands through a response queue.
module vu_vmu_ctrl_ut_mc
    import vu_vmu_ut_pkg::*;
#(
    parameter int unsigned VLEN_SZ   = VlenSzDef,
    parameter int unsigned ADDR_SZ   = AddrSzDef,
    parameter int unsigned CMD_SZ    = CmdSzDef,
    parameter bit          AMO_IMM   = 1'b0,
    parameter int unsigned ERRCNT_SZ = ErrCntSzDef
) (
    input  logic                 clk,
    input  logic                 reset_n,
    vu_vmu_ctrl_ut_mc_if.master  ctrl_if,
    input  logic                 issue_busy,
    input  logic                 store_busy,
    output logic [ERRCNT_SZ-1:0] err_cnt
);

    logic [CMD_SZ-1:0]  cmd;
    logic [VLEN_SZ-1:0] vlen;
    logic [ADDR_SZ-1:0] addr;
    logic               cmd_val;
    logic               is_ld, is_st, is_amo, is_sync, is_inv;
    logic               ld_fire, st_fire, amo_fire;

    state_e                 state_q, state_d;
    resp_e                  code_q, code_d;
    logic                   inv_pend_q, inv_pend_d;
    logic [ERRCNT_SZ-1:0]   err_cnt_q, err_cnt_d;

    logic  cmd_rdy, imm_rdy, resp_val, is_val, wb_val, st_val;
    resp_e resp_code;

    assign cmd     = ctrl_if.utmcmdq_bits[VLEN_SZ +: CMD_SZ];
    assign vlen    = ctrl_if.utmcmdq_bits[VLEN_SZ-1:0];
    assign addr    = ctrl_if.utmimmq_bits;
    assign cmd_val = ctrl_if.utmcmdq_val;

    vu_vmu_ut_decode u_decode (
        .cmd_i     (cmd[7:2]),
        .is_ld_o   (is_ld),
        .is_st_o   (is_st),
        .is_amo_o  (is_amo),
        .is_sync_o (is_sync),
        .is_inv_o  (is_inv)
    );

    // Loads wait for stores to drain and vice versa; AMOs touch both paths.
    assign ld_fire  = cmd_val & is_ld & ctrl_if.utmimmq_val & ctrl_if.iscmdq_enq_rdy
                    & ctrl_if.wbcmdq_enq_rdy & ~store_busy;
    assign st_fire  = cmd_val & is_st & ctrl_if.utmimmq_val & ctrl_if.stcmdq_enq_rdy
                    & ~issue_busy;
    assign amo_fire = cmd_val & is_amo & (ctrl_if.utmimmq_val | ~AMO_IMM)
                    & ctrl_if.stcmdq_enq_rdy & ctrl_if.wbcmdq_enq_rdy & ~issue_busy;

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        inv_pend_d = 1'b0;
        err_cnt_d  = err_cnt_q;
        cmd_rdy    = 1'b0;
        imm_rdy    = 1'b0;
        resp_val   = 1'b0;
        resp_code  = RespNone;
        is_val     = 1'b0;
        wb_val     = 1'b0;
        st_val     = 1'b0;

        case (state_q)
            StIdle: begin
                if (ld_fire) begin
                    cmd_rdy = 1'b1;
                    imm_rdy = 1'b1;
                    is_val  = 1'b1;
                    wb_val  = 1'b1;
                end else if (st_fire) begin
                    cmd_rdy = 1'b1;
                    imm_rdy = 1'b1;
                    st_val  = 1'b1;
                end else if (amo_fire) begin
                    cmd_rdy = 1'b1;
                    imm_rdy = AMO_IMM;
                    st_val  = 1'b1;
                    wb_val  = 1'b1;
                end else if (cmd_val & is_sync) begin
                    state_d = StSync;
                end else if (cmd_val & is_inv) begin
                    state_d    = StResp;
                    code_d     = RespErr;
                    inv_pend_d = 1'b1;
                end
            end

            StSync: begin
                if (~store_busy & ~issue_busy) begin
                    cmd_rdy   = 1'b1;
                    resp_val  = 1'b1;
                    resp_code = RespSync;
                    if (ctrl_if.utmrespq_rdy) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StResp;
                        code_d  = RespSync;
                    end
                end
            end

            StResp: begin
                resp_val  = 1'b1;
                resp_code = code_q;
                // An invalid command is popped and counted only on its first cycle here.
                if (inv_pend_q) begin
                    cmd_rdy = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERRCNT_SZ'(1);
                    end
                end
                if (ctrl_if.utmrespq_rdy) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            code_q     <= RespNone;
            inv_pend_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            inv_pend_q <= inv_pend_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign ctrl_if.utmcmdq_rdy     = cmd_rdy;
    assign ctrl_if.utmimmq_rdy     = imm_rdy;
    assign ctrl_if.utmrespq_val    = resp_val;
    assign ctrl_if.utmrespq_bits   = resp_code;
    assign ctrl_if.iscmdq_enq_val  = is_val;
    assign ctrl_if.wbcmdq_enq_val  = wb_val;
    assign ctrl_if.stcmdq_enq_val  = st_val;
    assign ctrl_if.iscmdq_enq_bits = {addr, vlen};
    assign ctrl_if.wbcmdq_enq_bits = {is_amo, cmd[WbCmdSz-1:0], vlen};
    assign ctrl_if.stcmdq_enq_bits = {is_amo, cmd[StCmdSz-1:0], addr, vlen};

    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_vu_vmu_ctrl_ut_mc.sv
// Self-checking bench: vector table, directed multi-cycle sequences and
// randomized traffic against a transaction-level model of the controller.
module tb_vu_vmu_ctrl_ut_mc;

    localparam int unsigned VlenSz = 11;
    localparam int unsigned AddrSz = 32;
    localparam int unsigned CmdSz  = 8;
    localparam int unsigned ErrSz  = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [ErrSz-1:0] err_cnt;

    logic [7:0]        cmd_r = '0;
    logic [VlenSz-1:0] vlen_r = '0;
    logic [AddrSz-1:0] addr_r = '0;
    logic cv = 0, iv = 0, isr = 1, wbr = 1, str = 1, rr = 1, ib = 0, sb = 0;

    vu_vmu_ctrl_ut_mc_if #(.VLEN_SZ(VlenSz), .ADDR_SZ(AddrSz), .CMD_SZ(CmdSz)) bus ();

    assign bus.utmcmdq_bits   = {cmd_r, vlen_r};
    assign bus.utmcmdq_val    = cv;
    assign bus.utmimmq_bits   = addr_r;
    assign bus.utmimmq_val    = iv;
    assign bus.utmrespq_rdy   = rr;
    assign bus.iscmdq_enq_rdy = isr;
    assign bus.wbcmdq_enq_rdy = wbr;
    assign bus.stcmdq_enq_rdy = str;

    vu_vmu_ctrl_ut_mc #(
        .VLEN_SZ   (VlenSz),
        .ADDR_SZ   (AddrSz),
        .CMD_SZ    (CmdSz),
        .AMO_IMM   (1'b0),
        .ERRCNT_SZ (ErrSz)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ctrl_if    (bus),
        .issue_busy (ib),
        .store_busy (sb),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: what the controller owes the response queue, not how it encodes it.
    bit draining_q = 0;      // sync accepted, waiting for both units to go idle
    bit resp_owed  = 0;      // a response is being offered
    int resp_code  = 0;
    bit pop_owed   = 0;      // invalid command not yet popped/counted
    int errs_seen  = 0;
    bit n_drain, n_owed, n_pop;
    int n_code, n_errs;

    typedef struct {
        logic [7:0] cmd;
        logic [6:0] ins;   // {cmd_val, imm_val, is_rdy, wb_rdy, st_rdy, issue_busy, store_busy}
        logic [4:0] exp;   // {cmd_rdy, imm_rdy, is_val, wb_val, st_val}
    } vec_t;
    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        cv = 0; iv = 0; isr = 1; wbr = 1; str = 1; rr = 1; ib = 0; sb = 0;
    endtask

    // Settle, predict the outputs for this cycle and compare.
    task automatic eval();
        bit e_cr, e_ir, e_is, e_wb, e_st, e_rv, amo;
        int e_rb, op;
        longint unsigned e_isb, e_wbb, e_stb;
        #1;
        {e_cr, e_ir, e_is, e_wb, e_st, e_rv} = '0;
        e_rb = 0;
        n_drain = draining_q; n_owed = resp_owed; n_code = resp_code; n_pop = 0;
        n_errs = errs_seen;
        op  = int'(cmd_r) / 16;
        amo = (op >= 14);
        if (draining_q) begin
            if (!sb && !ib) begin
                e_cr = 1; e_rv = 1; e_rb = 1;
                n_drain = 0;
                n_owed  = !rr;
                n_code  = 1;
            end
        end else if (resp_owed) begin
            e_rv = 1; e_rb = resp_code;
            if (pop_owed) begin
                e_cr = 1;
                n_errs = (errs_seen + 1 > 255) ? 255 : errs_seen + 1;
            end
            if (rr) n_owed = 0;
        end else if (cv) begin
            if (op == 12) begin
                if (iv && isr && wbr && !sb) begin e_cr = 1; e_ir = 1; e_is = 1; e_wb = 1; end
            end else if (op == 13) begin
                if (iv && str && !ib) begin e_cr = 1; e_ir = 1; e_st = 1; end
            end else if (amo) begin
                if (str && wbr && !ib) begin e_cr = 1; e_st = 1; e_wb = 1; end
            end else if (op == 0 && (int'(cmd_r) % 16) >= 12) begin
                n_drain = 1;
            end else begin
                n_owed = 1; n_code = 2; n_pop = 1;
            end
        end
        e_isb = (64'(addr_r) << VlenSz) | 64'(vlen_r);
        e_wbb = (64'(amo) << 15) | (64'(cmd_r % 16) << VlenSz) | 64'(vlen_r);
        e_stb = (64'(amo) << 48) | (64'(cmd_r % 32) << 43) | e_isb;
        chk("cmd_rdy", bus.utmcmdq_rdy, e_cr);
        chk("imm_rdy", bus.utmimmq_rdy, e_ir);
        chk("is_val", bus.iscmdq_enq_val, e_is);
        chk("wb_val", bus.wbcmdq_enq_val, e_wb);
        chk("st_val", bus.stcmdq_enq_val, e_st);
        chk("resp_val", bus.utmrespq_val, e_rv);
        if (e_rv) chk("resp_bits", bus.utmrespq_bits, e_rb);
        if (e_is) chk("is_bits", bus.iscmdq_enq_bits, e_isb);
        if (e_wb) chk("wb_bits", bus.wbcmdq_enq_bits, e_wbb);
        if (e_st) chk("st_bits", bus.stcmdq_enq_bits, e_stb);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            draining_q = 0; resp_owed = 0; resp_code = 0; pop_owed = 0; errs_seen = 0;
        end else begin
            draining_q = n_drain; resp_owed = n_owed; resp_code = n_code;
            pop_owed = n_pop; errs_seen = n_errs;
        end
        #1;
        chk("err_cnt", err_cnt, errs_seen);
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 0;
        eval(); tick();
        reset_n = 1;
    endtask

    initial begin
        int pops, resps, cyc;
        int r;

        vecs[0]  = '{8'hC0, 7'b1111100, 5'b11110};
        vecs[1]  = '{8'hC0, 7'b1011100, 5'b00000};
        vecs[2]  = '{8'hC0, 7'b1111101, 5'b00000};
        vecs[3]  = '{8'hC0, 7'b1101100, 5'b00000};
        vecs[4]  = '{8'hC3, 7'b1111110, 5'b11110};
        vecs[5]  = '{8'hD3, 7'b1111101, 5'b11001};
        vecs[6]  = '{8'hD3, 7'b1111000, 5'b00000};
        vecs[7]  = '{8'hD3, 7'b1111110, 5'b00000};
        vecs[8]  = '{8'hE0, 7'b1011100, 5'b10011};
        vecs[9]  = '{8'hF5, 7'b1110100, 5'b00000};
        vecs[10] = '{8'hF5, 7'b1111101, 5'b10011};
        vecs[11] = '{8'h0C, 7'b0111100, 5'b00000};
        vecs[12] = '{8'h20, 7'b0111100, 5'b00000};
        vecs[13] = '{8'hC0, 7'b0111100, 5'b00000};

        set_idle();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        eval();
        chk("rst_resp_val", bus.utmrespq_val, 0);
        chk("rst_cmd_rdy", bus.utmcmdq_rdy, 0);
        chk("rst_err_cnt", err_cnt, 0);
        tick();

        for (int i = 0; i < 14; i++) begin
            cmd_r = vecs[i].cmd; vlen_r = 11'(i * 37); addr_r = 32'h1000 + 32'(i);
            {cv, iv, isr, wbr, str, ib, sb} = vecs[i].ins;
            eval();
            chk($sformatf("vec%0d_handshake", i),
                {bus.utmcmdq_rdy, bus.utmimmq_rdy, bus.iscmdq_enq_val,
                 bus.wbcmdq_enq_val, bus.stcmdq_enq_val}, vecs[i].exp);
            tick();
        end

        // Back-to-back loads.
        set_idle();
        for (int k = 0; k < 3; k++) begin
            cmd_r = 8'hC0; vlen_r = 11'd7; addr_r = 32'h100 * 32'(k + 1); cv = 1; iv = 1;
            eval();
            chk("ld_is_val", bus.iscmdq_enq_val, 1);
            chk("ld_is_bits", bus.iscmdq_enq_bits, (64'(k + 1) << 19) | 64'd7);
            chk("ld_wb_amo", bus.wbcmdq_enq_bits[15], 0);
            tick();
        end

        // Store held off by issue_busy.
        set_idle();
        cmd_r = 8'hD0; vlen_r = 11'd3; addr_r = 32'h40; cv = 1; iv = 1; ib = 1;
        for (int k = 0; k < 5; k++) begin
            ib = (k < 4);
            eval();
            chk("st_pop", bus.utmcmdq_rdy, (k == 4) ? 1 : 0);
            chk("st_val", bus.stcmdq_enq_val, (k == 4) ? 1 : 0);
            if (k == 4) chk("st_amo", bus.stcmdq_enq_bits[48], 0);
            tick();
        end

        // AMO without an immediate.
        set_idle();
        cmd_r = 8'hE0; vlen_r = 11'd5; cv = 1; iv = 0;
        eval();
        chk("amo_pop", bus.utmcmdq_rdy, 1);
        chk("amo_imm_rdy", bus.utmimmq_rdy, 0);
        chk("amo_wb_amo", bus.wbcmdq_enq_bits[15], 1);
        chk("amo_st_amo", bus.stcmdq_enq_bits[48], 1);
        tick();

        // Sync waiting on store drain, then a stalled response.
        set_idle();
        cmd_r = 8'h0C; cv = 1; sb = 1; rr = 0;
        for (int k = 0; k < 7; k++) begin
            sb = (k < 3);
            cv = (k < 4);
            rr = (k >= 5);
            eval();
            chk("sync_pop", bus.utmcmdq_rdy, (k == 3) ? 1 : 0);
            chk("sync_resp_val", bus.utmrespq_val, (k >= 3 && k <= 5) ? 1 : 0);
            if (k >= 3 && k <= 5) chk("sync_code", bus.utmrespq_bits, 1);
            tick();
        end

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      cmd_r = 8'hC0 | 8'($urandom_range(0, 15));
            else if (r < 5) cmd_r = 8'hD0 | 8'($urandom_range(0, 15));
            else if (r < 7) cmd_r = 8'hE0 | 8'($urandom_range(0, 31));
            else if (r < 8) cmd_r = 8'h0C | 8'($urandom_range(0, 3));
            else            cmd_r = 8'($urandom_range(0, 191));
            vlen_r = 11'($urandom); addr_r = $urandom;
            cv  = ($urandom_range(0, 3) != 0);
            iv  = ($urandom_range(0, 3) != 0);
            isr = ($urandom_range(0, 3) != 0);
            wbr = ($urandom_range(0, 3) != 0);
            str = ($urandom_range(0, 3) != 0);
            rr  = ($urandom_range(0, 2) != 0);
            ib  = ($urandom_range(0, 3) == 0);
            sb  = ($urandom_range(0, 3) == 0);
            reset_n = ($urandom_range(0, 99) != 0);
            eval();
            tick();
        end

        // Invalid commands saturate the error counter.
        do_reset();
        cmd_r = 8'h20; cv = 1; rr = 1;
        pops = 0; resps = 0; cyc = 0;
        while (pops < 300 && cyc < 1000) begin
            eval();
            if (bus.utmcmdq_rdy) pops++;
            if (bus.utmrespq_val && bus.utmrespq_bits == 2'd2) resps++;
            cv = (pops < 300);
            tick();
            cyc++;
        end
        chk("inv_pops", pops, 300);
        chk("inv_resps", resps, 300);
        chk("inv_err_sat", err_cnt, 255);

        // Reset while a response is pending.
        set_idle();
        cmd_r = 8'h20; cv = 1; rr = 0;
        eval(); tick();
        cv = 0; reset_n = 0;
        eval();
        chk("rstresp_pending", bus.utmrespq_val, 1);
        tick();
        reset_n = 1;
        eval();
        chk("rstresp_val", bus.utmrespq_val, 0);
        chk("rstresp_err_cnt", err_cnt, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
